// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg : shared types and constants for the redirect controller
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RS1 = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } redir_state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_JAL    = 2'd1,
    EV_JALR   = 2'd2,
    EV_BRANCH = 2'd3
  } redir_kind_t;

  localparam logic [31:0] ILEN_C = 32'd2;
  localparam logic [31:0] ILEN_N = 32'd4;

  // jal outranks jalr outranks branch, matching the offset-generator mux
  function automatic redir_kind_t decode_kind(input logic valid, input logic jal,
                                              input logic jalr, input logic branch,
                                              input logic taken);
    redir_kind_t k;
    k = EV_NONE;
    if (valid) begin
      if (jal)                 k = EV_JAL;
      else if (jalr)           k = EV_JALR;
      else if (branch & taken) k = EV_BRANCH;
    end
    return k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/redirect_target_calc.sv
// ---------------------------------------------------------------------------
// redirect_target_calc : combinational target / link / misalignment compute
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module redirect_target_calc
  import riscv_pkg::*;
#(
  parameter int C_EXT = 1
) (
  input  logic [31:0] i_pc_id,
  input  logic [31:0] i_branoff,
  input  logic        i_comp_sig,
  input  redir_kind_t i_kind,
  output logic [31:0] o_target,
  output logic [31:0] o_link_addr,
  output logic        o_misalign
);

  localparam bit C_ALIGN4 = (C_EXT == 0);

  logic [31:0] w_sum;

  assign w_sum = i_pc_id + i_branoff;

  always_comb begin
    o_target = w_sum;
    if (i_kind == EV_JALR) begin
      o_target = {i_branoff[31:1], 1'b0};
    end
  end

  // bit0 can only be set on the pc-relative path; jalr clears it above
  assign o_misalign  = o_target[0] | (C_ALIGN4 & o_target[1]);
  assign o_link_addr = i_pc_id + (i_comp_sig ? ILEN_C : ILEN_N);

endmodule

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl : redirect sequencing, jalr hazard stall, flush window
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int C_EXT        = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             i_valid_id,
  input  logic             i_branch,
  input  logic             i_jal,
  input  logic             i_jalr,
  input  logic             i_taken,
  input  logic             i_comp_sig,
  input  logic [31:0]      i_pc_id,
  input  logic [31:0]      i_branoff,
  input  logic             i_rs1_hazard,
  input  logic             i_stall_ext,
  output logic             o_stall_id,
  output logic             o_redirect,
  output logic [31:0]      o_target,
  output logic [31:0]      o_link_addr,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic             o_misalign_exc,
  output logic [CNT_W-1:0] o_taken_cnt
);

  localparam logic [2:0]       C_FLUSH_LAST = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  redir_state_t     r_state;
  logic [2:0]       r_fcnt;
  logic             r_redirect;
  logic             r_flush;
  logic             r_misalign_exc;
  logic [31:0]      r_target;
  logic [31:0]      r_link_addr;
  logic [CNT_W-1:0] r_taken_cnt;

  redir_kind_t      w_kind;
  logic             w_accept_state;
  logic [31:0]      w_target;
  logic [31:0]      w_link_addr;
  logic             w_misalign;

  // while waiting on rs1 the held instruction is known to be a jalr
  always_comb begin
    w_kind = decode_kind(i_valid_id, i_jal, i_jalr, i_branch, i_taken);
    if (r_state == WAIT_RS1) begin
      w_kind = EV_JALR;
    end
  end

  assign w_accept_state = (r_state == IDLE) || (r_state == WAIT_RS1);
  assign o_stall_id     = w_accept_state && (w_kind == EV_JALR) && i_rs1_hazard;

  redirect_target_calc #(
    .C_EXT (C_EXT)
  ) u_calc (
    .i_pc_id     (i_pc_id),
    .i_branoff   (i_branoff),
    .i_comp_sig  (i_comp_sig),
    .i_kind      (w_kind),
    .o_target    (w_target),
    .o_link_addr (w_link_addr),
    .o_misalign  (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_state        <= IDLE;
      r_fcnt         <= 3'd0;
      r_redirect     <= 1'b0;
      r_flush        <= 1'b0;
      r_misalign_exc <= 1'b0;
      r_target       <= 32'd0;
      r_link_addr    <= 32'd0;
      r_taken_cnt    <= '0;
    end else if (!i_stall_ext) begin
      r_redirect     <= 1'b0;
      r_misalign_exc <= 1'b0;
      case (r_state)
        IDLE, WAIT_RS1: begin
          if ((w_kind != EV_NONE) && !o_stall_id) begin
            r_link_addr <= w_link_addr;
            if (w_misalign) begin
              r_misalign_exc <= 1'b1;
              r_state        <= IDLE;
            end else begin
              r_state    <= REDIRECT;
              r_target   <= w_target;
              r_redirect <= 1'b1;
              r_flush    <= 1'b1;
              r_fcnt     <= 3'd1;
              if (r_taken_cnt != C_CNT_MAX) begin
                r_taken_cnt <= r_taken_cnt + C_CNT_ONE;
              end
            end
          end else if (o_stall_id) begin
            r_state <= WAIT_RS1;
          end
        end
        REDIRECT, FLUSH: begin
          // the flush window counts the REDIRECT cycle as its first cycle
          if (r_fcnt >= C_FLUSH_LAST) begin
            r_state <= IDLE;
            r_flush <= 1'b0;
            r_fcnt  <= 3'd0;
          end else begin
            r_state <= FLUSH;
            r_fcnt  <= r_fcnt + 3'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_redirect     = r_redirect;
  assign o_target       = r_target;
  assign o_link_addr    = r_link_addr;
  assign o_flush_if     = r_flush;
  assign o_flush_id     = r_flush;
  assign o_misalign_exc = r_misalign_exc;
  assign o_taken_cnt    = r_taken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl : two configurations checked against a cycle model
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        Rst;
  logic        valid_id, branch, jal, jalr, taken, comp_sig, rs1_hazard, stall_ext;
  logic [31:0] pc_id, branoff;

  logic        st0, rd0, fi0, fd0, ex0;
  logic        st1, rd1, fi1, fd1, ex1;
  logic [31:0] tg0, lk0, tg1, lk1;
  logic [15:0] cn0;
  logic [2:0]  cn1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .C_EXT(1), .CNT_W(16)) u0 (
    .clk(clk), .Rst(Rst), .i_valid_id(valid_id), .i_branch(branch), .i_jal(jal),
    .i_jalr(jalr), .i_taken(taken), .i_comp_sig(comp_sig), .i_pc_id(pc_id),
    .i_branoff(branoff), .i_rs1_hazard(rs1_hazard), .i_stall_ext(stall_ext),
    .o_stall_id(st0), .o_redirect(rd0), .o_target(tg0), .o_link_addr(lk0),
    .o_flush_if(fi0), .o_flush_id(fd0), .o_misalign_exc(ex0), .o_taken_cnt(cn0)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(1), .C_EXT(0), .CNT_W(3)) u1 (
    .clk(clk), .Rst(Rst), .i_valid_id(valid_id), .i_branch(branch), .i_jal(jal),
    .i_jalr(jalr), .i_taken(taken), .i_comp_sig(comp_sig), .i_pc_id(pc_id),
    .i_branoff(branoff), .i_rs1_hazard(rs1_hazard), .i_stall_ext(stall_ext),
    .o_stall_id(st1), .o_redirect(rd1), .o_target(tg1), .o_link_addr(lk1),
    .o_flush_if(fi1), .o_flush_id(fd1), .o_misalign_exc(ex1), .o_taken_cnt(cn1)
  );

  // ---- behavioural model: "remaining flush cycles" + "waiting jalr" ----
  bit          m_red[2], m_exc[2], m_wait[2];
  logic [31:0] m_tgt[2], m_link[2];
  int          m_cnt[2], m_rem[2];

  function automatic int fc_of(input int k);   return (k == 0) ? 2 : 1;      endfunction
  function automatic bit four_of(input int k); return (k == 1);              endfunction
  function automatic int max_of(input int k);  return (k == 0) ? 65535 : 7;  endfunction

  // 0 none, 1 jal, 2 jalr, 3 taken branch
  function automatic int kind_of(input int k);
    if (m_wait[k]) return 2;
    if (!valid_id) return 0;
    if (jal)       return 1;
    if (jalr)      return 2;
    if (branch && taken) return 3;
    return 0;
  endfunction

  function automatic bit exp_stall(input int k);
    return (m_rem[k] == 0) && (kind_of(k) == 2) && rs1_hazard;
  endfunction

  task automatic model_step(input int k);
    int          kd;
    logic [31:0] t;
    if (!Rst) begin
      m_red[k] = 0; m_exc[k] = 0; m_wait[k] = 0;
      m_tgt[k] = 0; m_link[k] = 0; m_cnt[k] = 0; m_rem[k] = 0;
    end else if (!stall_ext) begin
      m_red[k] = 0;
      m_exc[k] = 0;
      if (m_rem[k] > 0) begin
        m_rem[k]--;
      end else begin
        kd = kind_of(k);
        if (kd == 2 && rs1_hazard) begin
          m_wait[k] = 1;
        end else if (kd != 0) begin
          m_wait[k] = 0;
          t = (kd == 2) ? (branoff & 32'hFFFF_FFFE) : (pc_id + branoff);
          m_link[k] = pc_id + (comp_sig ? 32'd2 : 32'd4);
          if (t[0] || (four_of(k) && t[1])) begin
            m_exc[k] = 1;
          end else begin
            m_red[k] = 1;
            m_tgt[k] = t;
            m_rem[k] = fc_of(k);
            if (m_cnt[k] < max_of(k)) m_cnt[k]++;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("u0.stall_id",  32'(st0), 32'(exp_stall(0)));
    chk("u0.redirect",  32'(rd0), 32'(m_red[0]));
    chk("u0.flush_if",  32'(fi0), 32'(m_rem[0] > 0));
    chk("u0.flush_id",  32'(fd0), 32'(m_rem[0] > 0));
    chk("u0.misalign",  32'(ex0), 32'(m_exc[0]));
    chk("u0.target",    tg0, m_tgt[0]);
    chk("u0.link_addr", lk0, m_link[0]);
    chk("u0.taken_cnt", 32'(cn0), 32'(m_cnt[0]));
    chk("u1.stall_id",  32'(st1), 32'(exp_stall(1)));
    chk("u1.redirect",  32'(rd1), 32'(m_red[1]));
    chk("u1.flush_if",  32'(fi1), 32'(m_rem[1] > 0));
    chk("u1.flush_id",  32'(fd1), 32'(m_rem[1] > 0));
    chk("u1.misalign",  32'(ex1), 32'(m_exc[1]));
    chk("u1.target",    tg1, m_tgt[1]);
    chk("u1.link_addr", lk1, m_link[1]);
    chk("u1.taken_cnt", 32'(cn1), 32'(m_cnt[1]));
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  // ---- stimulus ----
  task automatic idle();
    valid_id = 0; branch = 0; jal = 0; jalr = 0; taken = 0; comp_sig = 0;
    rs1_hazard = 0; stall_ext = 0; pc_id = 32'd0; branoff = 32'd0;
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    Rst = 1'b0;
    cyc(2);
    Rst = 1'b1;
    chk("rst.redirect", 32'(rd0), 32'd0);
    chk("rst.flush",    32'(fi0), 32'd0);
    chk("rst.cnt",      32'(cn0), 32'd0);

    // jal: pc 0x100 + 0x20
    valid_id = 1; jal = 1; pc_id = 32'h100; branoff = 32'h20;
    cyc(); idle();
    chk("jal.redirect", 32'(rd0), 32'd1);
    chk("jal.target",   tg0, 32'h120);
    chk("jal.link",     lk0, 32'h104);
    chk("jal.flush1",   32'(fi0), 32'd1);
    chk("jal.cnt",      32'(cn0), 32'd1);
    cyc();
    chk("jal.flush2",    32'(fi0), 32'd1);
    chk("jal.redir2",    32'(rd0), 32'd0);
    chk("jal.u1.flush2", 32'(fi1), 32'd0);
    cyc();
    chk("jal.flush3", 32'(fi0), 32'd0);

    // branch not taken, then taken with negative offset
    valid_id = 1; branch = 1; taken = 0; pc_id = 32'h200; branoff = 32'h40;
    cyc();
    chk("bnt.redirect", 32'(rd0), 32'd0);
    chk("bnt.flush",    32'(fi0), 32'd0);
    chk("bnt.cnt",      32'(cn0), 32'd1);
    taken = 1; branoff = 32'hFFFF_FFF0;
    cyc(); idle();
    chk("bt.target", tg0, 32'h1F0);
    chk("bt.cnt",    32'(cn0), 32'd2);
    cyc(2);

    // jalr with a three-cycle rs1 hazard, compressed instruction
    valid_id = 1; jalr = 1; pc_id = 32'h400; comp_sig = 1; rs1_hazard = 1; branoff = 32'h999;
    #1 chk("jalr.stall1", 32'(st0), 32'd1);
    cyc();
    chk("jalr.stall2", 32'(st0), 32'd1);
    chk("jalr.nored2", 32'(rd0), 32'd0);
    cyc();
    chk("jalr.stall3", 32'(st0), 32'd1);
    cyc();
    rs1_hazard = 0; branoff = 32'h305;
    #1 chk("jalr.stall4", 32'(st0), 32'd0);
    cyc(); idle();
    chk("jalr.redirect", 32'(rd0), 32'd1);
    chk("jalr.target",   tg0, 32'h304);
    chk("jalr.link",     lk0, 32'h402);
    cyc(3);

    // 0x6 is fine with compressed support, misaligned without it
    valid_id = 1; jal = 1; pc_id = 32'h0; branoff = 32'h6;
    cyc(); idle();
    chk("mis.u0.redirect", 32'(rd0), 32'd1);
    chk("mis.u0.target",   tg0, 32'h6);
    chk("mis.u1.exc",      32'(ex1), 32'd1);
    chk("mis.u1.redirect", 32'(rd1), 32'd0);
    chk("mis.u1.flush",    32'(fi1), 32'd0);
    chk("mis.u1.link",     lk1, 32'h4);
    cyc();
    chk("mis.u1.exc2", 32'(ex1), 32'd0);
    cyc(2);

    // jal+jalr together held behind a two-cycle external stall
    valid_id = 1; jal = 1; jalr = 1; rs1_hazard = 1; pc_id = 32'h500; branoff = 32'h40;
    stall_ext = 1;
    cyc();
    chk("stl.redirect1", 32'(rd0), 32'd0);
    chk("stl.target1",   tg0, 32'h6);
    cyc();
    chk("stl.redirect2", 32'(rd0), 32'd0);
    chk("stl.cnt",       32'(cn0), 32'd4);
    stall_ext = 0;
    #1 chk("stl.stall_id", 32'(st0), 32'd0);
    cyc(); idle();
    chk("stl.redirect", 32'(rd0), 32'd1);
    chk("stl.target",   tg0, 32'h540);
    chk("stl.link",     lk0, 32'h504);
    cyc(3);

    // reset while in the flush window
    valid_id = 1; jal = 1; pc_id = 32'h600; branoff = 32'h10;
    cyc(); idle();
    cyc();
    chk("rf.flush", 32'(fi0), 32'd1);
    Rst = 0;
    cyc();
    Rst = 1;
    chk("rf.redirect", 32'(rd0), 32'd0);
    chk("rf.flush2",   32'(fi0), 32'd0);
    chk("rf.cnt",      32'(cn0), 32'd0);
    chk("rf.target",   tg0, 32'd0);
    cyc();

    // saturate the 3-bit counter of u1
    repeat (9) begin
      valid_id = 1; jal = 1; pc_id = 32'h700; branoff = 32'h8;
      cyc(); idle();
      cyc(3);
    end
    chk("sat.u1.cnt", 32'(cn1), 32'd7);
    chk("sat.u0.cnt", 32'(cn0), 32'd9);

    // randomized traffic
    repeat (4000) begin
      Rst        = ($urandom_range(0, 199) != 0);
      valid_id   = ($urandom_range(0, 3) != 0);
      jal        = ($urandom_range(0, 4) == 0);
      jalr       = ($urandom_range(0, 3) == 0);
      branch     = $urandom_range(0, 1);
      taken      = $urandom_range(0, 1);
      comp_sig   = $urandom_range(0, 1);
      rs1_hazard = ($urandom_range(0, 2) == 0);
      stall_ext  = ($urandom_range(0, 7) == 0);
      pc_id      = $urandom & 32'hFFFF_FFFE;
      branoff    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom;
      cyc();
    end
    idle();
    Rst = 1;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
